// File: rtl/mips32r1_wb_pkg.sv
// Shared types for the mips32r1 Wishbone arbiter: FSM states, grant codes, defaults.
// Pure declarations; no timing or flow-control behaviour of its own.
package mips32r1_wb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_GNT_M0 = 2'd1,
    ST_GNT_M1 = 2'd2
  } arb_state_t;

  // One-hot grant, bit order {M1,M0}
  localparam logic [1:0] GRANT_NONE = 2'b00;
  localparam logic [1:0] GRANT_M0   = 2'b01;
  localparam logic [1:0] GRANT_M1   = 2'b10;

  localparam int DEFAULT_TIMEOUT_CYCLES = 255;

  function automatic logic [1:0] grant_of(input arb_state_t s);
    case (s)
      ST_GNT_M0: grant_of = GRANT_M0;
      ST_GNT_M1: grant_of = GRANT_M1;
      default:   grant_of = GRANT_NONE;
    endcase
  endfunction

endpackage

// File: rtl/wb_watchdog.sv
// Counts stalled strobe cycles and flags abort combinationally when the limit is hit.
// Zero-latency abort; an ack or err in the limit cycle suppresses it. TIMEOUT_CYCLES=0 disables.
module wb_watchdog
  import mips32r1_wb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_active,
  input  logic i_stb,
  input  logic i_ack,
  input  logic i_err,
  output logic o_abort
);

  localparam int              CW     = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0]   LIMIT  = CW'(TIMEOUT_CYCLES);
  localparam bit              ENABLE = (TIMEOUT_CYCLES != 0);

  logic [CW-1:0] r_count;
  logic          w_stall;
  logic          w_abort;

  assign w_stall = i_active & i_stb & ~i_ack & ~i_err;
  assign w_abort = ENABLE && w_stall && (r_count == LIMIT);
  assign o_abort = w_abort;

  // Count never passes LIMIT: the abort cycle itself clears it
  always_ff @(posedge i_clk) begin
    if (i_rst || !w_stall || w_abort) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + 1'b1;
    end
  end

endmodule

// File: rtl/mips32r1_wb_arbiter.sv
// Round-robin two-master Wishbone classic arbiter (M0 fetch, M1 load/store) with bus watchdog.
// Grant one cycle after cyc in IDLE, held until cyc drops; loser stalls with no ack/err.
module mips32r1_wb_arbiter
  import mips32r1_wb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
  parameter int AW             = 32
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_i,
  input  logic [AW-1:0] m0_adr_i,
  input  logic          m0_stb_i,
  input  logic          m0_cyc_i,
  output logic [31:0]   m0_dat_o,
  output logic          m0_ack_o,
  output logic          m0_err_o,
  input  logic [AW-1:0] m1_adr_i,
  input  logic [31:0]   m1_dat_i,
  input  logic [3:0]    m1_sel_i,
  input  logic          m1_we_i,
  input  logic          m1_stb_i,
  input  logic          m1_cyc_i,
  output logic [31:0]   m1_dat_o,
  output logic          m1_ack_o,
  output logic          m1_err_o,
  output logic [AW-1:0] s_adr_o,
  output logic [31:0]   s_dat_o,
  output logic [3:0]    s_sel_o,
  output logic          s_we_o,
  output logic          s_stb_o,
  output logic          s_cyc_o,
  input  logic [31:0]   s_dat_i,
  input  logic          s_ack_i,
  input  logic          s_err_i,
  output logic [1:0]    grant_o,
  output logic          timeout_o
);

  arb_state_t r_state;
  arb_state_t w_state_nxt;
  logic       r_last_m1;
  logic       w_last_m1_nxt;

  logic       w_gnt_cyc;
  logic       w_gnt_stb;
  logic       w_is_m0;
  logic       w_is_m1;
  logic       w_abort;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_state   <= ST_IDLE;
      r_last_m1 <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_last_m1 <= w_last_m1_nxt;
    end
  end

  // A tie goes to whichever master did not hold the bus last
  always_comb begin
    w_state_nxt   = r_state;
    w_last_m1_nxt = r_last_m1;
    case (r_state)
      ST_IDLE: begin
        if (m0_cyc_i && m1_cyc_i) begin
          w_state_nxt = r_last_m1 ? ST_GNT_M0 : ST_GNT_M1;
        end else if (m0_cyc_i) begin
          w_state_nxt = ST_GNT_M0;
        end else if (m1_cyc_i) begin
          w_state_nxt = ST_GNT_M1;
        end
      end
      ST_GNT_M0: begin
        if (!m0_cyc_i) begin
          w_state_nxt   = ST_IDLE;
          w_last_m1_nxt = 1'b0;
        end
      end
      ST_GNT_M1: begin
        if (!m1_cyc_i) begin
          w_state_nxt   = ST_IDLE;
          w_last_m1_nxt = 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // M0 is read-only, so its write-side fields are fixed
  always_comb begin
    s_adr_o   = '0;
    s_dat_o   = '0;
    s_sel_o   = '0;
    s_we_o    = 1'b0;
    w_gnt_cyc = 1'b0;
    w_gnt_stb = 1'b0;
    w_is_m0   = 1'b0;
    w_is_m1   = 1'b0;
    case (r_state)
      ST_GNT_M0: begin
        w_is_m0   = 1'b1;
        s_adr_o   = m0_adr_i;
        s_sel_o   = 4'hF;
        w_gnt_cyc = m0_cyc_i;
        w_gnt_stb = m0_stb_i;
      end
      ST_GNT_M1: begin
        w_is_m1   = 1'b1;
        s_adr_o   = m1_adr_i;
        s_dat_o   = m1_dat_i;
        s_sel_o   = m1_sel_i;
        s_we_o    = m1_we_i;
        w_gnt_cyc = m1_cyc_i;
        w_gnt_stb = m1_stb_i;
      end
      default: ;
    endcase
  end

  wb_watchdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_watchdog (
    .i_clk    (wb_clk_i),
    .i_rst    (wb_rst_i),
    .i_active (w_is_m0 | w_is_m1),
    .i_stb    (w_gnt_stb & w_gnt_cyc),
    .i_ack    (s_ack_i),
    .i_err    (s_err_i),
    .o_abort  (w_abort)
  );

  assign grant_o   = grant_of(r_state);
  assign s_cyc_o   = w_gnt_cyc & ~w_abort;
  assign s_stb_o   = w_gnt_stb & ~w_abort;
  assign timeout_o = w_abort;

  assign m0_dat_o  = s_dat_i;
  assign m1_dat_o  = s_dat_i;
  assign m0_ack_o  = s_ack_i & w_is_m0;
  assign m1_ack_o  = s_ack_i & w_is_m1;
  assign m0_err_o  = (s_err_i | w_abort) & w_is_m0;
  assign m1_err_o  = (s_err_i | w_abort) & w_is_m1;

endmodule

// File: doc/mips32r1_wb_arbiter.md
# mips32r1_wb_arbiter

Two-master Wishbone B3 classic arbiter sharing one slave port between the instruction master (M0, `iwbm_*`) and data master (M1, `dwbm_*`) of `mips32r1_wb`.

- Sits between the core and one interconnect slave port, so a single-ported slave (boot ROM, SRAM) can serve both fetch and load/store.
- Round-robin grant, held for the whole `cyc` cycle.
- Bus watchdog terminates stalled cycles with `err`.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 255: stalled-strobe cycles before abort; 0 disables the watchdog.
- `AW`, default 32: address width.

Ports (clock and reset first). One clock; reset is synchronous and active-high.
- `wb_clk_i`  in  1  system clock.
- `wb_rst_i`  in  1  synchronous reset.
- `m0_adr_i`  in  AW  M0 address.
- `m0_stb_i`, `m0_cyc_i`  in  1 each  M0 strobe, cycle.
- `m0_dat_o`  out  32  M0 read data.
- `m0_ack_o`, `m0_err_o`  out  1 each  M0 ack, error.
- `m1_adr_i`  in  AW  M1 address.
- `m1_dat_i`  in  32  M1 write data.
- `m1_sel_i`  in  4  M1 byte select.
- `m1_we_i`, `m1_stb_i`, `m1_cyc_i`  in  1 each  M1 write enable, strobe, cycle.
- `m1_dat_o`  out  32  M1 read data.
- `m1_ack_o`, `m1_err_o`  out  1 each  M1 ack, error.
- `s_adr_o`  out  AW  slave address.
- `s_dat_o`  out  32  slave write data.
- `s_sel_o`  out  4  slave byte select.
- `s_we_o`, `s_stb_o`, `s_cyc_o`  out  1 each  slave write enable, strobe, cycle.
- `s_dat_i`  in  32  slave read data.
- `s_ack_i`, `s_err_i`  in  1 each  slave ack, error.
- `grant_o`  out  2  one-hot current grant ({M1,M0}); 00 = idle.
- `timeout_o`  out  1  one-cycle pulse on watchdog abort.

## Operation
State machine:
- States are IDLE, GNT_M0 and GNT_M1.
- Reset forces IDLE, `last_m1=0` and watchdog count 0.
- IDLE with only `m0_cyc_i` set: next state GNT_M0.
- IDLE with only `m1_cyc_i` set: next state GNT_M1.
- IDLE with both set: grant the master not granted last. After reset the first tie goes to M1.
- GNT_Mx, granted `cyc` low: return to IDLE next cycle and update `last_m1`.
- GNT_Mx, granted `cyc` high: stay, regardless of the other master's request. There is no preemption.

Output muxing:
- `s_*` outputs are combinational copies of the granted master's signals.
- M0 has no write path. When M0 is granted: `s_we_o=0`, `s_sel_o=4'hF`, `s_dat_o=0`.
- In IDLE all `s_*` outputs are 0.
- `s_dat_i` is routed to both `m0_dat_o` and `m1_dat_o`.
- `mx_ack_o = s_ack_i & granted(x)`.
- `mx_err_o = (s_err_i | abort) & granted(x)`.
- The non-granted master always sees ack=err=0.

Watchdog:
- Counter width is `$clog2(TIMEOUT_CYCLES+1)`.
- Increments each cycle with state≠IDLE, granted `stb=1` and `s_ack_i=s_err_i=0`.
- Clears on ack, on err, on `stb=0`, or in IDLE.
- `abort` = count==`TIMEOUT_CYCLES` (comb). In the abort cycle:
  - `s_cyc_o` and `s_stb_o` are forced 0;
  - granted `err` is asserted;
  - `timeout_o` is asserted;
  - the counter clears.
- Slave ack in the same cycle as abort: ack wins, no abort, `timeout_o=0`.

## Timing
- Reset values: all outputs 0, except `m*_dat_o`, which follow `s_dat_i`.
- Arbitration latency: one cycle. `cyc` rising in IDLE at edge N gives grant and `s_cyc_o` during cycle N+1.
- Ack/err/data path from slave to master is combinational, zero latency.
- Handover costs one IDLE cycle between consecutive grants (M0 release → M1 grant: 1 dead cycle).
- A master held continuously in `cyc` monopolises the bus. Masters must drop `cyc` between cycles, as `mips32r1_wb` does.
- Granted master dropping `cyc` mid-transfer: the slave sees `s_cyc_o=0` immediately; FSM is IDLE next cycle.
- Reset mid-transfer: IDLE at the next edge, `s_cyc_o=0` from that edge; no ack/err is generated.

## Structure
- Shared package `mips32r1_wb_pkg`:
  - state enum (IDLE/GNT_M0/GNT_M1);
  - grant encodings;
  - default `TIMEOUT_CYCLES`.
- One natural sub-module is `wb_watchdog`. Inputs: clk, rst, `active`, `stb`, `ack`, `err`. Output: `abort`. Parameter: `TIMEOUT_CYCLES`.

## Test plan
- M0-only read: M0 cyc/stb, `s_ack_i` 2 cycles later with `s_dat_i=32'hDEADBEEF` → `grant_o=01`, `m0_ack_o` and `m0_dat_o=DEADBEEF` in the ack cycle, `m1_ack_o=0`.
- Simultaneous first request after reset → M1 granted first; after M1 drops cyc, one IDLE cycle, then M0 granted. A second tie is granted to M0.
- M1 write `adr=32'h0000_1004`, `dat=32'h12345678`, `sel=4'b0011`, `we=1` → identical values on `s_*`. A concurrent M0 request stays stalled (ack=0) until release.
- `TIMEOUT_CYCLES=8`, slave never acks → `m1_err_o` and `timeout_o` pulse exactly 8 cycles after the `s_stb_o` rise, with `s_cyc_o=0` in that cycle; next grant proceeds normally.
- Ack in the exact abort cycle → ack delivered, no err, `timeout_o=0`.
- `wb_rst_i` pulsed during a granted stalled cycle → `grant_o=00` and all `s_*` outputs 0 from the next edge; the first tie after reset goes to M1.
